// File: rtl/sin_nco_seq_pkg.sv
// Shared definitions for the dual-channel sine NCO sequencer: FSM encoding and
// default widths/offsets.
package sin_nco_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_A  = 2'd1,
    ST_RD_B  = 2'd2,
    ST_CAP_B = 2'd3
  } nco_state_e;

  localparam int NCO_SINBITS       = 16;
  localparam int NCO_SINSAMPLEBITS = 8;
  localparam int NCO_PHASEBITS     = 24;
  localparam logic [NCO_PHASEBITS-1:0] NCO_B_OFFSET = 24'h400000;

endpackage

// File: rtl/nco_phase_acc.sv
// Unsigned phase accumulator wrapping modulo 2^W, with a synchronous load of
// clr_val that takes priority over accumulation.
module nco_phase_acc #(
  parameter int          W       = 24,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic         en,
  input  logic [W-1:0] ftw,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = clr_val;
    end else if (en) begin
      acc_d = acc_q + ftw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= RST_VAL;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/sin_nco_seq.sv
// Dual-channel NCO sequencer: one shared single-port sine BRAM is read for
// channel A then channel B per accepted sample_tick, then both phases advance.
module sin_nco_seq
  import sin_nco_seq_pkg::*;
#(
  parameter int SINBITS       = NCO_SINBITS,
  parameter int SINSAMPLEBITS = NCO_SINSAMPLEBITS,
  parameter int PHASEBITS     = NCO_PHASEBITS,
  parameter logic [PHASEBITS-1:0] B_OFFSET = NCO_B_OFFSET
) (
  input  logic                     nco_clk,
  input  logic                     nco_rst,
  input  logic                     sample_tick,
  input  logic                     phase_clr,
  input  logic                     ftw_we,
  input  logic                     ftw_sel,
  input  logic [PHASEBITS-1:0]     ftw_data,
  output logic                     bram_ce,
  output logic [SINSAMPLEBITS-1:0] bram_addr,
  input  logic [SINBITS-1:0]       bram_data,
  output logic [SINBITS-1:0]       sin_a,
  output logic [SINBITS-1:0]       sin_b,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [1:0]               dbg_state
);

  // Handshake: sample_tick is a single-cycle request taken only in ST_IDLE;
  // there is no ready, so a tick in any other state is dropped and flagged
  // in the sticky overrun bit. sample_valid is a one-cycle result strobe.

  nco_state_e state_q, state_d;
  logic                     bram_ce_q, bram_ce_d;
  logic [SINSAMPLEBITS-1:0] bram_addr_q, bram_addr_d;
  logic [SINBITS-1:0]       sin_a_q, sin_a_d;
  logic [SINBITS-1:0]       sin_b_q, sin_b_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic [PHASEBITS-1:0]     ftw_a_q, ftw_a_d;
  logic [PHASEBITS-1:0]     ftw_b_q, ftw_b_d;
  logic [PHASEBITS-1:0]     acc_a, acc_b;
  logic                     acc_en;

  always_comb begin
    state_d     = state_q;
    bram_ce_d   = bram_ce_q;
    bram_addr_d = bram_addr_q;
    sin_a_d     = sin_a_q;
    sin_b_d     = sin_b_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    ftw_a_d     = ftw_a_q;
    ftw_b_d     = ftw_b_q;
    acc_en      = 1'b0;

    if (phase_clr) begin
      // Abort without a valid pulse; samples and tuning words are kept.
      state_d   = ST_IDLE;
      bram_ce_d = 1'b0;
      busy_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (ftw_we) begin
        if (ftw_sel) ftw_b_d = ftw_data;
        else         ftw_a_d = ftw_data;
      end
      if (sample_tick && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (sample_tick) begin
            bram_ce_d   = 1'b1;
            bram_addr_d = acc_a[PHASEBITS-1 -: SINSAMPLEBITS];
            busy_d      = 1'b1;
            state_d     = ST_RD_A;
          end
        end
        ST_RD_A: begin
          bram_addr_d = acc_b[PHASEBITS-1 -: SINSAMPLEBITS];
          state_d     = ST_RD_B;
        end
        ST_RD_B: begin
          sin_a_d   = bram_data;
          bram_ce_d = 1'b0;
          state_d   = ST_CAP_B;
        end
        ST_CAP_B: begin
          sin_b_d = bram_data;
          valid_d = 1'b1;
          acc_en  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge nco_clk or posedge nco_rst) begin
    if (nco_rst) begin
      state_q     <= ST_IDLE;
      bram_ce_q   <= 1'b0;
      bram_addr_q <= '0;
      sin_a_q     <= '0;
      sin_b_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      ftw_a_q     <= '0;
      ftw_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      bram_ce_q   <= bram_ce_d;
      bram_addr_q <= bram_addr_d;
      sin_a_q     <= sin_a_d;
      sin_b_q     <= sin_b_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      ftw_a_q     <= ftw_a_d;
      ftw_b_q     <= ftw_b_d;
    end
  end

  // Accumulators see the registered tuning words, so a write landing on the
  // advance edge only affects the following sample.
  nco_phase_acc #(.W(PHASEBITS), .RST_VAL('0)) u_acc_a (
    .clk     (nco_clk),
    .rst     (nco_rst),
    .clr     (phase_clr),
    .clr_val ('0),
    .en      (acc_en),
    .ftw     (ftw_a_q),
    .acc     (acc_a)
  );

  nco_phase_acc #(.W(PHASEBITS), .RST_VAL(B_OFFSET)) u_acc_b (
    .clk     (nco_clk),
    .rst     (nco_rst),
    .clr     (phase_clr),
    .clr_val (B_OFFSET),
    .en      (acc_en),
    .ftw     (ftw_b_q),
    .acc     (acc_b)
  );

  assign bram_ce      = bram_ce_q;
  assign bram_addr    = bram_addr_q;
  assign sin_a        = sin_a_q;
  assign sin_b        = sin_b_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sin_nco_seq.sv
// Self-checking bench for sin_nco_seq: sine BRAM stand-in, sample-level
// behavioural model with a per-cycle compare, and directed scenarios.
module tb_sin_nco_seq;

  localparam int PB = 24;
  localparam int SB = 16;
  localparam int AB = 8;
  localparam logic [PB-1:0] BOFF = 24'h400000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sample_tick = 1'b0;
  logic          phase_clr   = 1'b0;
  logic          ftw_we      = 1'b0;
  logic          ftw_sel     = 1'b0;
  logic [PB-1:0] ftw_data    = '0;
  logic          bram_ce;
  logic [AB-1:0] bram_addr;
  logic [SB-1:0] bram_data = '0;
  logic [SB-1:0] sin_a, sin_b;
  logic          sample_valid, busy, overrun;
  logic [1:0]    dbg_state;

  sin_nco_seq dut (
    .nco_clk      (clk),
    .nco_rst      (rst),
    .sample_tick  (sample_tick),
    .phase_clr    (phase_clr),
    .ftw_we       (ftw_we),
    .ftw_sel      (ftw_sel),
    .ftw_data     (ftw_data),
    .bram_ce      (bram_ce),
    .bram_addr    (bram_addr),
    .bram_data    (bram_data),
    .sin_a        (sin_a),
    .sin_b        (sin_b),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // Sine table contents: any distinct-ish pattern works for checking routing.
  function automatic logic [SB-1:0] tv(input int i);
    return 16'((i * 40503 + 4660) ^ (i << 9));
  endfunction

  always @(posedge clk) begin
    if (bram_ce) bram_data <= tv(int'(bram_addr));
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  logic [AB-1:0] rd_log[$];
  logic [AB-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_seq counts the edges still to come in an accepted read (3 after accept).
  int            m_seq;
  logic [AB-1:0] m_pa, m_pb;
  logic [PB-1:0] m_acc_a, m_acc_b, m_ftw_a, m_ftw_b;
  logic          m_ov, m_valid;
  logic [SB-1:0] m_sa, m_sb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_seq = 0; m_pa = '0; m_pb = '0;
      m_acc_a = '0; m_acc_b = BOFF; m_ftw_a = '0; m_ftw_b = '0;
      m_ov = 1'b0; m_valid = 1'b0; m_sa = '0; m_sb = '0;
    end else begin
      m_valid = 1'b0;
      if (phase_clr) begin
        m_acc_a = '0; m_acc_b = BOFF; m_seq = 0; m_ov = 1'b0;
      end else begin
        if (m_seq != 0) begin
          if (sample_tick) m_ov = 1'b1;
          m_seq = m_seq - 1;
          if (m_seq == 1) m_sa = tv(int'(m_pa));
          if (m_seq == 0) begin
            m_sb = tv(int'(m_pb));
            m_valid = 1'b1;
            m_acc_a = m_acc_a + m_ftw_a;
            m_acc_b = m_acc_b + m_ftw_b;
          end
        end else if (sample_tick) begin
          m_pa  = m_acc_a[PB-1 -: AB];
          m_pb  = m_acc_b[PB-1 -: AB];
          m_seq = 3;
        end
        if (ftw_we) begin
          if (ftw_sel) m_ftw_b = ftw_data;
          else         m_ftw_a = ftw_data;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_seq != 0));
    chk("bram_ce", 32'(bram_ce), 32'(m_seq == 3 || m_seq == 2));
    if (m_seq == 3 || m_seq == 2)
      chk("bram_addr", 32'(bram_addr), 32'((m_seq == 3) ? m_pa : m_pb));
    chk("sin_a", 32'(sin_a), 32'(m_sa));
    chk("sin_b", 32'(sin_b), 32'(m_sb));
    chk("overrun", 32'(overrun), 32'(m_ov));
    if (bram_ce) rd_log.push_back(bram_addr);
    if (sample_valid) n_valid++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic clr();
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
  endtask

  task automatic write_ftw(input logic sel, input logic [PB-1:0] val);
    ftw_we = 1'b1; ftw_sel = sel; ftw_data = val;
    step(1);
    ftw_we = 1'b0;
  endtask

  task automatic check_log(input string name);
    #1;
    chk({name, "_len"}, 32'(rd_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rd_log.size(); i++)
      chk(name, 32'(rd_log[i]), 32'(exp_q[i]));
    rd_log.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    step(2);
    #1;
    chk("rst_sin_a", 32'(sin_a), 0);
    chk("rst_sin_b", 32'(sin_b), 0);
    chk("rst_ce", 32'(bram_ce), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 0);
    @(negedge clk) rst = 1'b0;
    step(2);

    // 1: basic pairs, tick every 8 cycles
    write_ftw(1'b0, 24'h010000);
    write_ftw(1'b1, 24'h010000);
    rd_log.delete(); n_valid = 0;
    repeat (3) begin tick(); step(7); end
    exp_q = {8'h00, 8'h40, 8'h01, 8'h41, 8'h02, 8'h42};
    check_log("t1_addr");
    chk("t1_valids", 32'(n_valid), 3);
    chk("t1_sin_a", 32'(sin_a), 32'(tv(2)));
    chk("t1_sin_b", 32'(sin_b), 32'(tv(8'h42)));

    // 2: spacing 4 accepted, spacing 3 drops and sets overrun
    clr();
    n_valid = 0;
    tick(); step(3); tick(); step(3); tick(); step(7);
    #1;
    chk("t2_no_overrun", 32'(overrun), 0);
    chk("t2_valids4", 32'(n_valid), 3);
    tick(); step(2); tick(); step(7);
    #1;
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_valids3", 32'(n_valid), 4);
    rd_log.delete();

    // 3: large steps and wrap-down on B
    write_ftw(1'b0, 24'h800000);
    write_ftw(1'b1, 24'hFF0000);
    clr();
    #1 chk("t3_ov_clear", 32'(overrun), 0);
    rd_log.delete();
    repeat (3) begin tick(); step(7); end
    exp_q = {8'h00, 8'h40, 8'h80, 8'h3F, 8'h00, 8'h3E};
    check_log("t3_addr");

    // 4: phase_clr at T1 aborts the sequence
    tick(); step(2); tick(); step(7);
    n_valid = 0;
    tick();
    phase_clr = 1'b1;
    step(1);
    phase_clr = 1'b0;
    #1;
    chk("t4_ce", 32'(bram_ce), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_overrun", 32'(overrun), 0);
    step(6);
    chk("t4_no_valid", 32'(n_valid), 0);
    rd_log.delete();
    tick(); step(7);
    exp_q = {8'h00, 8'h40};
    check_log("t4_addr");

    // 5: FTW write landing on the T3 edge applies to the next sample
    clr();
    write_ftw(1'b0, 24'h010000);
    rd_log.delete();
    tick(); step(2);
    ftw_we = 1'b1; ftw_sel = 1'b0; ftw_data = 24'h100000;
    step(1);
    ftw_we = 1'b0;
    step(4);
    tick(); step(7);
    tick(); step(7);
    exp_q = {8'h00, 8'h40, 8'h01, 8'h3F, 8'h11, 8'h3E};
    check_log("t5_addr");

    // 6: async reset mid-sequence
    tick(); step(1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_sin_a", 32'(sin_a), 0);
    chk("t6_sin_b", 32'(sin_b), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ce", 32'(bram_ce), 0);
    chk("t6_state", 32'(dbg_state), 0);
    @(negedge clk) rst = 1'b0;
    step(2);
    rd_log.delete();
    tick(); step(7);
    exp_q = {8'h00, 8'h40};
    check_log("t6_addr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
